// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered 32-bit ALU among N requesters
module alu_arbiter #(
  parameter int N  = 4,
  parameter int PW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [32*N-1:0] req_a,
  input  logic [32*N-1:0] req_b,
  input  logic [3*N-1:0]  req_op,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    resp_valid,
  output logic [31:0]     resp_data,
  output logic            resp_err,
  input  logic [N-1:0]    resp_ready
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RESP = 1'b1;

  logic [0:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_own;
  logic [N-1:0]  r_resp_valid;
  logic [31:0]   r_resp_data;
  logic          r_resp_err;

  logic          w_own_ready;
  logic          w_grant_ok;
  logic          w_found;
  logic [PW-1:0] w_gnt;
  logic [PW-1:0] w_ptr_next;
  logic [N-1:0]  w_req_ready;
  logic          w_accept;
  logic [31:0]   w_a;
  logic [31:0]   w_b;
  logic [2:0]    w_op;
  logic [31:0]   w_res;
  logic          w_err;

  always_comb begin
    w_own_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_own == PW'(i)) w_own_ready = resp_ready[i];
    end
  end

  // Only the current owner's consume can free the output register for a new grant.
  assign w_grant_ok = (r_state == S_IDLE) || w_own_ready;

  // Pick the valid requester with the smallest rotational distance from r_ptr.
  always_comb begin
    int best_d;
    int d;
    best_d  = N;
    d       = 0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < N; i++) begin
      d = i - int'(r_ptr);
      if (d < 0) d = d + N;
      if (req_valid[i] && (d < best_d)) begin
        best_d  = d;
        w_gnt   = PW'(i);
        w_found = 1'b1;
      end
    end
  end

  assign w_accept   = rst_n && w_grant_ok && w_found;
  assign w_ptr_next = (w_gnt == PW'(N - 1)) ? '0 : w_gnt + PW'(1);

  always_comb begin
    w_req_ready = '0;
    w_a         = '0;
    w_b         = '0;
    w_op        = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == PW'(i)) begin
        w_req_ready[i] = w_accept;
        w_a            = req_a[32*i +: 32];
        w_b            = req_b[32*i +: 32];
        w_op           = req_op[3*i +: 3];
      end
    end
  end

  assign req_ready = w_req_ready;

  // Shift amount is the full 32-bit B; anything >= 32 saturates.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (w_op)
      3'b000: w_res = w_a + w_b;
      3'b001: w_res = w_a - w_b;
      3'b010: w_res = w_a & w_b;
      3'b011: w_res = w_a | w_b;
      3'b100: w_res = (w_b >= 32'd32) ? 32'd0 : (w_a >> w_b[4:0]);
      3'b101: w_res = (w_b >= 32'd32) ? {32{w_a[31]}} : 32'($signed(w_a) >>> w_b[4:0]);
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_own        <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_state      <= S_RESP;
      r_ptr        <= w_ptr_next;
      r_own        <= w_gnt;
      r_resp_valid <= w_req_ready;
      r_resp_data  <= w_res;
      r_resp_err   <= w_err;
    end else if ((r_state == S_RESP) && w_own_ready) begin
      r_state      <= S_IDLE;
      r_resp_valid <= '0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter
module tb_alu_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [3*N-1:0]  req_op;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic [N-1:0]    resp_ready;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.N(N), .PW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic run_op(input string tag, input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp, input logic exp_err);
    logic [N-1:0] oh;
    oh         = N'(1) << i;
    set_req(i, a, b, op);
    req_valid  = oh;
    resp_ready = '1;
    #1;
    check({tag, "_rdy"}, 32'(req_ready), 32'(oh));
    tick;
    req_valid = '0;
    check({tag, "_vld"}, 32'(resp_valid), 32'(oh));
    check({tag, "_data"}, resp_data, exp);
    check({tag, "_err"}, 32'(resp_err), 32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int gs [8];
    logic [N-1:0] masks [8];
    gs    = '{0, 1, 2, 3, 0, 2, 3, 0};
    masks = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101, 4'b1101};

    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = '0;
    tick;
    tick;
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    #1;
    check("post_rst_first_grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    tick;
    check("no_accept_idle", 32'(resp_valid), 32'h0);

    run_op("add_wrap", 2, 32'h7FFFFFFF, 32'h1, 3'b000, 32'h80000000, 1'b0);
    run_op("sub", 2, 32'h0, 32'h1, 3'b001, 32'hFFFFFFFF, 1'b0);
    run_op("sra4", 2, 32'h80000000, 32'd4, 3'b101, 32'hF8000000, 1'b0);
    run_op("illegal", 2, 32'h1234, 32'h5678, 3'b111, 32'h0, 1'b1);
    run_op("sra40", 2, 32'h80000000, 32'd40, 3'b101, 32'hFFFFFFFF, 1'b0);
    run_op("and", 2, 32'hF0F0_1234, 32'h0FF0_FF00, 3'b010, 32'h00F0_1200, 1'b0);
    run_op("srl40", 2, 32'hFFFFFFFF, 32'd40, 3'b100, 32'h0, 1'b0);
    run_op("srl4", 2, 32'h80000000, 32'd4, 3'b100, 32'h08000000, 1'b0);
    tick;
    check("consume_vld", 32'(resp_valid), 32'h0);
    check("consume_hold_data", resp_data, 32'h08000000);

    // Build a pending response for requester 1, then reset mid-response.
    set_req(1, 32'd5, 32'd6, 3'b000);
    req_valid  = 4'b0010;
    resp_ready = '0;
    #1;
    check("r1_rdy", 32'(req_ready), 32'h2);
    tick;
    req_valid = '0;
    check("r1_vld", 32'(resp_valid), 32'h2);
    check("r1_data", resp_data, 32'd11);
    #2;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("async_rst_vld", 32'(resp_valid), 32'h0);
    check("async_rst_data", resp_data, 32'h0);
    check("async_rst_rdy", 32'(req_ready), 32'h0);
    tick;
    rst_n      = 1'b1;
    resp_ready = '1;
    for (int i = 0; i < N; i++) set_req(i, 32'(100 + i), 32'(i), 3'b000);

    for (int j = 0; j < 8; j++) begin
      req_valid = masks[j];
      #1;
      check($sformatf("rr_rdy%0d", j), 32'(req_ready), 32'(1) << gs[j]);
      tick;
      check($sformatf("rr_vld%0d", j), 32'(resp_valid), 32'(1) << gs[j]);
      check($sformatf("rr_data%0d", j), resp_data, 32'(100 + 2 * gs[j]));
    end

    req_valid = 4'b0010;
    #1;
    check("bp_rdy1", 32'(req_ready), 32'h2);
    tick;
    check("bp_vld1", 32'(resp_valid), 32'h2);
    check("bp_data1", resp_data, 32'd102);
    resp_ready = 4'b1101;
    req_valid  = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_stall_rdy%0d", k), 32'(req_ready), 32'h0);
      check($sformatf("bp_stall_data%0d", k), resp_data, 32'd102);
      tick;
    end
    check("bp_stall_vld", 32'(resp_valid), 32'h2);
    resp_ready = '1;
    #1;
    check("bp_release_rdy", 32'(req_ready), 32'h4);
    tick;
    check("bp_release_vld", 32'(resp_valid), 32'h4);
    check("bp_release_data", resp_data, 32'd104);

    req_valid = '0;
    tick;
    check("self_idle", 32'(resp_valid), 32'h0);
    set_req(0, 32'd10, 32'd1, 3'b000);
    req_valid  = 4'b0001;
    resp_ready = 4'b0001;
    #1;
    check("self_rdy1", 32'(req_ready), 32'h1);
    tick;
    check("self_data1", resp_data, 32'd11);
    set_req(0, 32'd20, 32'd2, 3'b000);
    #1;
    check("self_rdy2", 32'(req_ready), 32'h1);
    tick;
    check("self_vld2", 32'(resp_valid), 32'h1);
    check("self_data2", resp_data, 32'd22);
    set_req(0, 32'd30, 32'd3, 3'b000);
    resp_ready = 4'b0000;
    #1;
    check("self_stall_rdy", 32'(req_ready), 32'h0);
    tick;
    check("self_stall_data", resp_data, 32'd22);
    check("self_stall_vld", 32'(resp_valid), 32'h1);
    resp_ready = 4'b0001;
    #1;
    check("self_rdy3", 32'(req_ready), 32'h1);
    tick;
    check("self_data3", resp_data, 32'd33);
    req_valid = '0;
    tick;
    check("self_done_vld", 32'(resp_valid), 32'h0);
    check("self_done_data", resp_data, 32'd33);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
